inst_fetcher: RTL and testbench

INST_FETCHER -- requirements
Module: inst_fetcher

---
 rtl/inst_fetcher.sv | 153 +++++++++++++++
 tb/tb_inst_fetcher.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// Instruction fetcher: presents icache hits to the decoder and refills misses from memory.
// Optional build macro IFETCH_JAL_PREDICT_EN enables static JAL target prediction.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] ic_addr,
  input  logic [31:0] ic_data,
  input  logic        ic_len,
  input  logic        ic_hit,
  input  logic [31:0] ic_miss_addr,
  output logic [31:0] ic_wdata,
  output logic        ic_we,
  output logic        ic_block,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_len,
  output logic        pred_taken,
  input  logic        flush_in,
  input  logic [31:0] flush_pc
);

  // state | meaning
  // FETCH | look up pc in the icache, issue hits to the decoder
  // MEM   | refill request outstanding, waiting for mem_ack
  // FILL  | one-cycle icache write of the returned data
  // DRAIN | flushed while waiting; swallow the pending ack, no write
  typedef enum logic [1:0] {FETCH, MEM, FILL, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        inst_valid_nxt, inst_len_nxt, pred_taken_nxt;
  logic [31:0] inst_out_nxt, inst_pc_nxt;
  logic        mem_req_nxt, ic_we_nxt;
  logic [31:0] mem_addr_nxt, ic_wdata_nxt;
  logic        slot_free;
  logic        is_jal;
  logic [31:0] jal_imm;

`ifdef IFETCH_JAL_PREDICT_EN
  assign is_jal  = ic_len && (ic_data[6:0] == 7'b1101111);
  assign jal_imm = {{12{ic_data[31]}}, ic_data[19:12], ic_data[20], ic_data[30:21], 1'b0};
`else
  assign is_jal  = 1'b0;
  assign jal_imm = 32'h0000_0000;
`endif

  assign ic_addr   = pc;
  assign ic_block  = (state != FILL);
  assign slot_free = !inst_valid || inst_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst_out   <= 32'h0;
      inst_pc    <= 32'h0;
      inst_len   <= 1'b0;
      pred_taken <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0;
      ic_we      <= 1'b0;
      ic_wdata   <= 32'h0;
    end else if (rdy_in) begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst_valid <= inst_valid_nxt;
      inst_out   <= inst_out_nxt;
      inst_pc    <= inst_pc_nxt;
      inst_len   <= inst_len_nxt;
      pred_taken <= pred_taken_nxt;
      mem_req    <= mem_req_nxt;
      mem_addr   <= mem_addr_nxt;
      ic_we      <= ic_we_nxt;
      ic_wdata   <= ic_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    inst_valid_nxt = inst_valid && !inst_ready;
    inst_out_nxt   = inst_out;
    inst_pc_nxt    = inst_pc;
    inst_len_nxt   = inst_len;
    pred_taken_nxt = pred_taken;
    mem_req_nxt    = mem_req;
    mem_addr_nxt   = mem_addr;
    ic_we_nxt      = 1'b0;
    ic_wdata_nxt   = ic_wdata;

    unique case (state)
      FETCH: begin
        if (flush_in) begin
          // handled below
        end else if (ic_hit) begin
          if (slot_free) begin
            inst_valid_nxt = 1'b1;
            inst_out_nxt   = ic_data;
            inst_pc_nxt    = pc;
            inst_len_nxt   = ic_len;
            pred_taken_nxt = is_jal;
            pc_nxt         = is_jal ? pc + jal_imm : pc + (ic_len ? 32'd4 : 32'd2);
          end
        end else begin
          mem_addr_nxt = ic_miss_addr;
          mem_req_nxt  = 1'b1;
          state_nxt    = MEM;
        end
      end
      MEM: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          if (flush_in) begin
            state_nxt = FETCH;
          end else begin
            ic_wdata_nxt = mem_data;
            ic_we_nxt    = 1'b1;
            state_nxt    = FILL;
          end
        end else if (flush_in) begin
          state_nxt = DRAIN;
        end
      end
      FILL: begin
        state_nxt = FETCH;
      end
      DRAIN: begin
        // An ack arriving alongside a flush still ends the drain; otherwise it would never come
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          state_nxt   = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase

    if (flush_in) begin
      pc_nxt         = flush_pc;
      inst_valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed icache/memory stimulus with
// scoreboards for decoder deliveries and icache refill writes.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [31:0] ic_addr, ic_wdata, mem_addr, inst_out, inst_pc;
  logic [31:0] ic_data = 32'h0, ic_miss_addr = 32'h0, mem_data = 32'h0, flush_pc = 32'h0;
  logic        ic_len = 1'b0, ic_hit = 1'b0, mem_ack = 1'b0, inst_ready = 1'b1, flush_in = 1'b0;
  logic        ic_we, ic_block, mem_req, inst_valid, inst_len, pred_taken;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        len;
    logic        pred;
  } exp_inst_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } exp_wr_t;

  exp_inst_t iq[$];
  exp_wr_t   wq[$];
  int n_chk  = 0;
  int n_pass = 0;

  inst_fetcher #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ic_addr(ic_addr), .ic_data(ic_data), .ic_len(ic_len), .ic_hit(ic_hit),
    .ic_miss_addr(ic_miss_addr), .ic_wdata(ic_wdata), .ic_we(ic_we), .ic_block(ic_block),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_len(inst_len), .pred_taken(pred_taken),
    .flush_in(flush_in), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic push_inst(input logic [31:0] pc, input logic [31:0] data, input logic len,
                           input logic pred);
    exp_inst_t e;
    e.pc = pc; e.data = data; e.len = len; e.pred = pred;
    iq.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] data, input logic [31:0] addr);
    exp_wr_t e;
    e.data = data; e.addr = addr;
    wq.push_back(e);
  endtask

  // Decoder consumes on valid&&ready; the icache takes a write on each enabled FILL cycle
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (inst_valid && inst_ready) begin
        chk("inst_expected", 32'(iq.size() != 0), 32'd1);
        if (iq.size() != 0) begin
          exp_inst_t e;
          e = iq.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_out", inst_out, e.data);
          chk("inst_len", 32'(inst_len), 32'(e.len));
          chk("pred_taken", 32'(pred_taken), 32'(e.pred));
        end
      end
      if (ic_we && rdy_in) begin
        chk("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          exp_wr_t w;
          w = wq.pop_front();
          chk("ic_wdata", ic_wdata, w.data);
          chk("ic_we_addr", ic_addr, w.addr);
        end
      end
    end
  end

  initial begin
    cyc(2);
    chk("rst_ic_addr", ic_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ic_we", 32'(ic_we), 32'd0);
    chk("rst_ic_block", 32'(ic_block), 32'd1);
    chk("rst_pred", 32'(pred_taken), 32'd0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_ic_wdata", ic_wdata, 32'h0);
    rst_in = 1'b0;

    // all-miss refill of the first instruction, two halfwords
    ic_hit = 1'b0; ic_miss_addr = 32'h0;
    cyc(1);
    chk("miss_mem_req", 32'(mem_req), 32'd1);
    chk("miss_mem_addr", mem_addr, 32'h0);
    cyc(2);
    chk("mem_req_hold", 32'(mem_req), 32'd1);
    chk("no_we_in_mem", 32'(ic_we), 32'd0);
    mem_ack = 1'b1; mem_data = 32'h0000_0513;
    push_wr(32'h0000_0513, 32'h0);
    cyc(1);
    mem_ack = 1'b0; mem_data = 32'h0;
    chk("fill_we", 32'(ic_we), 32'd1);
    chk("fill_block", 32'(ic_block), 32'd0);
    chk("fill_mem_req", 32'(mem_req), 32'd0);
    ic_miss_addr = 32'h2;
    cyc(1);
    chk("fill_one_cycle", 32'(ic_we), 32'd0);
    chk("block_after_fill", 32'(ic_block), 32'd1);
    cyc(1);
    chk("miss2_mem_addr", mem_addr, 32'h2);
    mem_ack = 1'b1; mem_data = 32'hABCD_0000;
    push_wr(32'hABCD_0000, 32'h0);
    cyc(1);
    mem_ack = 1'b0;

    // back-to-back hits: 32-bit at 0x00, 16-bit at 0x04
    ic_hit = 1'b1; ic_len = 1'b1; ic_data = 32'h0000_0513;
    push_inst(32'h0, 32'h0000_0513, 1'b1, 1'b0);
    cyc(1);
    chk("fill_back_to_fetch", ic_addr, 32'h0);
    cyc(1);
    ic_len = 1'b0; ic_data = 32'h0000_4501;
    push_inst(32'h4, 32'h0000_4501, 1'b0, 1'b0);
    cyc(1);
    chk("pc_after_pair", ic_addr, 32'h6);

    // decoder stall: outputs hold, pc frozen
    inst_ready = 1'b0; ic_len = 1'b1; ic_data = 32'h0020_8093;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst_pc", inst_pc, 32'h4);
      chk("stall_inst_out", inst_out, 32'h0000_4501);
      chk("stall_pc", ic_addr, 32'h6);
    end
    inst_ready = 1'b1;
    push_inst(32'h6, 32'h0020_8093, 1'b1, 1'b0);
    cyc(1);
    chk("pc_after_stall", ic_addr, 32'hA);
    ic_hit = 1'b0; ic_miss_addr = 32'hA;
    cyc(1);
    chk("miss_a_req", 32'(mem_req), 32'd1);
    chk("miss_a_addr", mem_addr, 32'hA);
    chk("slot_drained", 32'(inst_valid), 32'd0);

    // flush while waiting on memory -> DRAIN, ack swallowed
    flush_in = 1'b1; flush_pc = 32'h100;
    cyc(1);
    flush_in = 1'b0;
    chk("drain_pc", ic_addr, 32'h100);
    chk("drain_req", 32'(mem_req), 32'd1);
    cyc(2);
    chk("drain_req_hold", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    cyc(1);
    mem_ack = 1'b0;
    chk("drain_done_req", 32'(mem_req), 32'd0);
    chk("drain_no_we", 32'(ic_we), 32'd0);
    chk("after_drain_addr", ic_addr, 32'h100);

    // hit and flush in the same cycle
    ic_hit = 1'b1; ic_len = 1'b1; ic_data = 32'h0000_0013;
    flush_in = 1'b1; flush_pc = 32'h200;
    cyc(1);
    flush_in = 1'b0;
    chk("hitflush_valid", 32'(inst_valid), 32'd0);
    chk("hitflush_pc", ic_addr, 32'h200);

    // flush coinciding with mem_ack discards the data
    ic_hit = 1'b0; ic_miss_addr = 32'h200;
    cyc(1);
    mem_ack = 1'b1; mem_data = 32'h5555_5555; flush_in = 1'b1; flush_pc = 32'h300;
    cyc(1);
    mem_ack = 1'b0; flush_in = 1'b0;
    chk("ackflush_req", 32'(mem_req), 32'd0);
    chk("ackflush_we", 32'(ic_we), 32'd0);
    chk("ackflush_pc", ic_addr, 32'h300);

    // rdy_in low freezes everything, including an in-flight FILL
    ic_miss_addr = 32'h300; rdy_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      chk("frozen_fetch_req", 32'(mem_req), 32'd0);
    end
    rdy_in = 1'b1;
    cyc(1);
    chk("thaw_req", 32'(mem_req), 32'd1);
    chk("thaw_addr", mem_addr, 32'h300);
    rdy_in = 1'b0; mem_ack = 1'b1; mem_data = 32'h0000_7777;
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      chk("frozen_mem_req", 32'(mem_req), 32'd1);
      chk("frozen_mem_we", 32'(ic_we), 32'd0);
    end
    rdy_in = 1'b1;
    push_wr(32'h0000_7777, 32'h300);
    cyc(1);
    mem_ack = 1'b0; rdy_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      chk("frozen_fill_we", 32'(ic_we), 32'd1);
      chk("frozen_fill_data", ic_wdata, 32'h0000_7777);
    end
    rdy_in = 1'b1;
    cyc(1);
    chk("unfrozen_fill_done", 32'(ic_we), 32'd0);

    // pc wrap at the top of the address space
    flush_in = 1'b1; flush_pc = 32'hFFFF_FFFE;
    cyc(1);
    flush_in = 1'b0;
    ic_hit = 1'b1; ic_len = 1'b0; ic_data = 32'h0000_0001;
    push_inst(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    cyc(1);
    chk("pc_wrap", ic_addr, 32'h0);

    // JAL at 0x40, offset +0x10
    ic_hit = 1'b0; flush_in = 1'b1; flush_pc = 32'h40;
    cyc(1);
    flush_in = 1'b0;
    ic_hit = 1'b1; ic_len = 1'b1; ic_data = 32'h0100_006F;
`ifdef IFETCH_JAL_PREDICT_EN
    push_inst(32'h40, 32'h0100_006F, 1'b1, 1'b1);
    cyc(1);
    chk("jal_target", ic_addr, 32'h50);
`else
    push_inst(32'h40, 32'h0100_006F, 1'b1, 1'b0);
    cyc(1);
    chk("jal_sequential", ic_addr, 32'h44);
`endif
    ic_hit = 1'b0; ic_miss_addr = 32'h1000;
    cyc(2);
    chk("pre_reset_req", 32'(mem_req), 32'd1);

    // asynchronous reset mid-refill, checked before any clock edge
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_pc", ic_addr, 32'h0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_block", 32'(ic_block), 32'd1);
    cyc(1);
    rst_in = 1'b0;
    cyc(1);

    chk("inst_q_empty", 32'(iq.size()), 32'd0);
    chk("wr_q_empty", 32'(wq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
